// File: rtl/wav_sample_player_if.sv
// wav_sample_player_if: ROM read bus between the sample player and its sample ROM
interface wav_sample_player_if #(parameter int AW = 19);
  logic [AW-1:0] rom_ab;
  logic rom_rd;
  logic [7:0] rom_db;
  logic rom_ack;
  modport master (output rom_ab, rom_rd, input rom_db, rom_ack);
  modport slave (input rom_ab, rom_rd, output rom_db, rom_ack);
endinterface

// File: rtl/wav_sample_player.sv
// wav_sample_player: priority-triggered PCM sample player fetching bytes from ROM
module wav_sample_player #(
  parameter int NCH = 3,
  parameter int CW = 2,
  parameter int AW = 19,
  parameter int LW = 13,
  parameter int SAMPLE_CNT = 2228,
  parameter logic [NCH*AW-1:0] BASE_TBL = {19'h13000, 19'h11000, 19'h10000},
  parameter logic [NCH*LW-1:0] LEN_TBL = {13'h1751, 13'h1E21, 13'h07D1},
  parameter logic [NCH-1:0] LOOP_MASK = '0
) (
  input logic I_CLK,
  input logic I_RSTn,
  input logic [NCH-1:0] I_SW,
  wav_sample_player_if.master rom,
  output logic [7:0] O_SAMPLE,
  output logic O_BUSY,
  output logic [CW-1:0] O_CH,
  output logic O_LATE
);
  localparam int TW = SAMPLE_CNT > 1 ? $clog2(SAMPLE_CNT) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [TW-1:0] cnt;
  logic tick;
  logic [NCH-1:0] s1, s2, trig;
  logic [LW-1:0] ptr, ptr_n;
  logic [AW-1:0] ab_n;
  logic [7:0] sample_n;
  logic [CW-1:0] ch_n, sel;
  logic rd_n, pend, pend_n, late_n, disc, disc_n, any, accept, go;

  function automatic logic [AW-1:0] base(input logic [CW-1:0] c);
    return BASE_TBL[int'(c)*AW +: AW];
  endfunction

  function automatic logic [LW-1:0] len(input logic [CW-1:0] c);
    return LEN_TBL[int'(c)*LW +: LW];
  endfunction

  assign trig = s1 & ~s2;
  assign accept = any && (state == IDLE || sel >= O_CH);
  assign O_BUSY = state != IDLE;

  // free-running sample-rate divider; tick is registered one cycle after the wrap count
  always_ff @(posedge I_CLK or negedge I_RSTn)
    if (!I_RSTn) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= cnt == TW'(SAMPLE_CNT - 1) ? '0 : cnt + TW'(1);
      tick <= cnt == TW'(SAMPLE_CNT - 1);
    end

  // two-flop synchroniser on the active-low triggers
  always_ff @(posedge I_CLK or negedge I_RSTn)
    if (!I_RSTn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ~I_SW;
      s2 <= s1;
    end

  // highest-index trigger wins
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (trig[i]) begin
        sel = CW'(i);
        any = 1'b1;
      end
  end

  // next state: new trigger, fetch/ack sequencing, pending tick and sample advance
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    ab_n = rom.rom_ab;
    sample_n = O_SAMPLE;
    ch_n = O_CH;
    pend_n = pend;
    late_n = O_LATE;
    disc_n = disc;
    go = 1'b0;
    if ((state == FETCH || state == WAIT) && tick) begin
      late_n = O_LATE | pend;
      pend_n = 1'b1;
    end
    if (accept && !(state == WAIT && !rom.rom_ack)) begin
      ch_n = sel;
      ptr_n = '0;
      ab_n = base(sel);
      state_n = FETCH;
      pend_n = 1'b0;
      disc_n = 1'b0;
    end else if (accept) begin
      ch_n = sel;
      ptr_n = '0;
      disc_n = 1'b1;
    end else if (state == FETCH)
      state_n = WAIT;
    else if (state == WAIT && rom.rom_ack && disc) begin
      ab_n = base(O_CH);
      state_n = FETCH;
      pend_n = 1'b0;
      disc_n = 1'b0;
    end else if (state == WAIT && rom.rom_ack) begin
      sample_n = rom.rom_db;
      state_n = HOLD;
      go = pend | tick;
      pend_n = 1'b0;
    end else if (state == HOLD)
      go = tick;
    if (go) begin
      if (ptr != len(O_CH) - LW'(1)) begin
        ptr_n = ptr + LW'(1);
        ab_n = base(O_CH) + AW'(ptr) + AW'(1);
        state_n = FETCH;
      end else if (LOOP_MASK[O_CH] && s1[O_CH]) begin
        ptr_n = '0;
        ab_n = base(O_CH);
        state_n = FETCH;
      end else begin
        sample_n = 8'h80;
        state_n = IDLE;
      end
    end
    rd_n = state_n == FETCH;
  end

  // state and output registers
  always_ff @(posedge I_CLK or negedge I_RSTn)
    if (!I_RSTn) begin
      state <= IDLE;
      ptr <= '0;
      rom.rom_ab <= '0;
      rom.rom_rd <= 1'b0;
      O_SAMPLE <= 8'h80;
      O_CH <= '0;
      O_LATE <= 1'b0;
      pend <= 1'b0;
      disc <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      rom.rom_ab <= ab_n;
      rom.rom_rd <= rd_n;
      O_SAMPLE <= sample_n;
      O_CH <= ch_n;
      O_LATE <= late_n;
      pend <= pend_n;
      disc <= disc_n;
    end
endmodule

// File: tb/tb_wav_sample_player.sv
// tb_wav_sample_player: randomized playback scenarios checked against a read-sequence model
module tb_wav_sample_player;
  localparam int SC = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] sw = '1;
  logic [7:0] sample;
  logic busy;
  logic [1:0] ch;
  logic late;
  int base_m[3] = '{32'h10000, 32'h11000, 32'h13000};
  int len_m[3] = '{4, 5, 7};
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int cd = 0;
  bit chk_smp = 1'b0;
  bit ack_prev = 1'b0;
  logic [7:0] seed;
  logic [7:0] exp_d;
  logic [7:0] smp;
  logic [18:0] pa;
  logic [18:0] reads[$];
  int rtimes[$];

  wav_sample_player_if #(.AW(19)) rom_if();

  wav_sample_player #(
    .SAMPLE_CNT(SC),
    .LEN_TBL({13'd7, 13'd5, 13'd4}),
    .LOOP_MASK(3'b001)
  ) dut (
    .I_CLK(clk),
    .I_RSTn(rst_n),
    .I_SW(sw),
    .rom(rom_if),
    .O_SAMPLE(sample),
    .O_BUSY(busy),
    .O_CH(ch),
    .O_LATE(late)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_data(input logic [18:0] a);
    return 8'(a * 7) + seed;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ROM responder with programmable latency, read logger and sample tracker
  initial begin
    rom_if.rom_ack = 1'b0;
    rom_if.rom_db = '0;
    forever begin
      @(negedge clk);
      if (ack_prev && chk_smp) check("sample", 32'(sample), 32'(exp_d));
      ack_prev = 1'b0;
      rom_if.rom_ack = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rom_if.rom_ack = 1'b1;
          rom_if.rom_db = rom_data(pa);
          exp_d = rom_if.rom_db;
          ack_prev = 1'b1;
        end
      end
      if (rom_if.rom_rd) begin
        pa = rom_if.rom_ab;
        cd = lat;
        reads.push_back(pa);
        rtimes.push_back(cyc);
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] m);
    sw = sw & ~m;
    tick_n(3);
    sw = sw | m;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle", 32'(busy), 0);
  endtask

  task automatic wait_reads(input int k, input int budget);
    int n = 0;
    while (reads.size() < k && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("reads_reached", 32'(reads.size() >= k), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ab"}, 32'(rom_if.rom_ab), 0);
    check({tag, "_rd"}, 32'(rom_if.rom_rd), 0);
    check({tag, "_sample"}, 32'(sample), 32'h80);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ch"}, 32'(ch), 0);
    check({tag, "_late"}, 32'(late), 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    tick_n(2);
    check_reset("rst");
    rst_n = 1'b1;
    tick_n(2);
  endtask

  task automatic clear_log;
    reads.delete();
    rtimes.delete();
  endtask

  initial begin
    int j;
    seed = 8'($urandom);
    tick_n(3);
    check_reset("por");
    rst_n = 1'b1;
    tick_n(2);

    // single channel-0 playback
    lat = $urandom_range(1, 3);
    clear_log();
    chk_smp = 1'b1;
    pulse(3'b001);
    check("s1_busy", 32'(busy), 1);
    check("s1_ch", 32'(ch), 0);
    wait_idle(200);
    chk_smp = 1'b0;
    check("s1_nreads", 32'(reads.size()), 32'(len_m[0]));
    for (int k = 0; k < reads.size(); k++) begin
      check("s1_addr", 32'(reads[k]), 32'(base_m[0] + k));
      if (k >= 2) check("s1_gap", 32'(rtimes[k] - rtimes[k-1]), SC);
    end
    check("s1_end_sample", 32'(sample), 32'h80);
    check("s1_late", 32'(late), 0);

    // higher channel preempts, lower channel is ignored
    lat = $urandom_range(1, 3);
    clear_log();
    pulse(3'b001);
    wait_reads(2, 100);
    tick_n($urandom_range(0, 12));
    pulse(3'b100);
    check("s2_ch", 32'(ch), 2);
    tick_n(20);
    pulse(3'b010);
    check("s2_ch_kept", 32'(ch), 2);
    wait_idle(300);
    j = -1;
    for (int k = 0; k < reads.size(); k++)
      if (j < 0 && reads[k] == 19'(base_m[2])) j = k;
    if (j < 0) j = reads.size();
    check("s2_prefix", 32'(j >= 2), 1);
    for (int k = 0; k < j; k++) check("s2_pre_addr", 32'(reads[k]), 32'(base_m[0] + k));
    check("s2_tail_len", 32'(reads.size() - j), 32'(len_m[2]));
    for (int k = j; k < reads.size(); k++) check("s2_tail_addr", 32'(reads[k]), 32'(base_m[2] + k - j));
    check("s2_end_sample", 32'(sample), 32'h80);

    // simultaneous triggers, then same-channel restart
    lat = $urandom_range(1, 3);
    clear_log();
    pulse(3'b110);
    check("s3_ch", 32'(ch), 2);
    tick_n($urandom_range(20, 60));
    pulse(3'b100);
    check("s3_ch_restart", 32'(ch), 2);
    wait_idle(300);
    j = -1;
    for (int k = 1; k < reads.size(); k++)
      if (j < 0 && reads[k] == 19'(base_m[2])) j = k;
    if (j < 0) j = reads.size();
    check("s3_first", reads.size() > 0 ? 32'(reads[0]) : 0, 32'(base_m[2]));
    for (int k = 0; k < j; k++) check("s3_pre_addr", 32'(reads[k]), 32'(base_m[2] + k));
    check("s3_tail_len", 32'(reads.size() - j), 32'(len_m[2]));
    for (int k = j; k < reads.size(); k++) check("s3_tail_addr", 32'(reads[k]), 32'(base_m[2] + k - j));

    // looping channel held low, then released
    lat = $urandom_range(1, 3);
    clear_log();
    chk_smp = 1'b1;
    sw[0] = 1'b0;
    wait_reads(3 * len_m[0], 400);
    tick_n($urandom_range(0, 63));
    sw[0] = 1'b1;
    wait_idle(300);
    chk_smp = 1'b0;
    check("s4_whole_loops", 32'(reads.size() % len_m[0]), 0);
    for (int k = 0; k < reads.size(); k++) check("s4_addr", 32'(reads[k]), 32'(base_m[0] + k % len_m[0]));
    check("s4_end_sample", 32'(sample), 32'h80);
    check("s4_late", 32'(late), 0);

    // ROM far slower than the sample rate
    do_reset();
    lat = SC * 5 / 2;
    clear_log();
    pulse(3'b010);
    wait_idle(600);
    check("s5_late", 32'(late), 1);
    check("s5_nreads", 32'(reads.size()), 32'(len_m[1]));
    for (int k = 0; k < reads.size(); k++) check("s5_addr", 32'(reads[k]), 32'(base_m[1] + k));
    tick_n(50);
    check("s5_late_sticky", 32'(late), 1);
    do_reset();

    // preemption during WAIT discards the outstanding data, then reset mid-WAIT
    lat = 10;
    clear_log();
    pulse(3'b001);
    wait_reads(2, 100);
    smp = sample;
    tick_n(1);
    pulse(3'b100);
    check("s6_ch", 32'(ch), 2);
    wait_reads(3, 60);
    check("s6_sample_kept", 32'(sample), 32'(smp));
    check("s6_new_base", reads.size() > 2 ? 32'(reads[2]) : 0, 32'(base_m[2]));
    tick_n(3);
    rst_n = 1'b0;
    tick_n(2);
    check_reset("s6_rst");
    rst_n = 1'b1;
    tick_n(15);
    check_reset("s6_post");
    check("s6_no_reads", 32'(reads.size()), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
